// File: rtl/alu4_regfile_seq.sv
// Operand/writeback sequencer for the 4-bit ALU: four-entry register file,
// {C,R,Z,V} flags, valid/ready command port. Optional macro: ALU4_SEQ_OPCOUNT_EN.
module alu4_regfile_seq #(
    parameter int         NREGS     = 4,
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_math_cin,
    output logic       alu_rot_cin,
    input  logic [3:0] alu_result,
    input  logic       alu_math_cout,
    input  logic       alu_rot_cout,
    input  logic       alu_zero,
    input  logic       alu_ovf,
    output logic [3:0] rd_data,
    output logic       rd_valid,
    output logic [3:0] flags,
    output logic [7:0] op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] regs_q [NREGS];
    logic [3:0] flags_q;
    logic [3:0] alu_a_q, alu_b_q, alu_op_q;
    logic [3:0] rd_data_q;
    logic       rd_valid_q;
    logic [1:0] dst_q;

    logic [1:0] kind;
    logic [3:0] imm;
    logic [1:0] ra, rb;
    logic       accept;

    assign kind   = cmd[9:8];
    assign imm    = cmd[7:4];
    assign ra     = cmd[3:2];
    assign rb     = cmd[1:0];

    assign cmd_ready = (state_q == IDLE) && rst_n;
    assign accept    = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: only an accepted ALU op leaves IDLE, EXEC always returns
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && kind == 2'b00) state_d = EXEC;
            EXEC: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register file, flags, ALU operand latches and read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 4'h0;
            flags_q    <= RST_FLAGS;
            alu_a_q    <= 4'h0;
            alu_b_q    <= 4'h0;
            alu_op_q   <= 4'h0;
            rd_data_q  <= 4'h0;
            rd_valid_q <= 1'b0;
            dst_q      <= 2'b00;
        end else begin
            rd_valid_q <= 1'b0;
            if (state_q == EXEC) begin
                regs_q[dst_q] <= alu_result;
                flags_q <= {alu_math_cout, alu_rot_cout,
                            alu_zero, alu_ovf};
            end else if (accept) begin
                unique case (kind)
                    2'b00: begin
                        alu_a_q  <= regs_q[ra];
                        alu_b_q  <= regs_q[rb];
                        alu_op_q <= imm;
                        dst_q    <= ra;
                    end
                    2'b01: regs_q[ra] <= imm;
                    2'b10: begin
                        rd_data_q  <= regs_q[ra];
                        rd_valid_q <= 1'b1;
                    end
                    2'b11: flags_q <= 4'b0000;
                    default: ;
                endcase
            end
        end
    end

`ifdef ALU4_SEQ_OPCOUNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Saturating writeback counter, cleared by a clear-flags command
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == EXEC) begin
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (accept && kind == 2'b11) begin
            cnt_d = 8'h00;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'h00;
        else        cnt_q <= cnt_d;
    end

    assign op_count = cnt_q;
`else
    assign op_count = 8'h00;
`endif

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_math_cin = flags_q[3];
    assign alu_rot_cin  = flags_q[2];
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign flags        = flags_q;

endmodule

// File: tb/tb_alu4_regfile_seq.sv
// Bench for alu4_regfile_seq: directed plan steps then random commands
// checked against an array/arithmetic model; the bench plays the ALU.
module tb_alu4_regfile_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd;
    logic [3:0] alu_a, alu_b, alu_op;
    logic       alu_math_cin, alu_rot_cin;
    logic [3:0] alu_result;
    logic       alu_math_cout, alu_rot_cout, alu_zero, alu_ovf;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic [3:0] flags;
    logic [7:0] op_count;

    int total = 0;
    int bad   = 0;

    logic [3:0] m_r [4];
    logic [3:0] m_f;
    logic [3:0] m_a, m_b, m_op, m_rd;
    int         m_cnt;

    always #5 clk = ~clk;

    alu4_regfile_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd          (cmd),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_math_cin (alu_math_cin),
        .alu_rot_cin  (alu_rot_cin),
        .alu_result   (alu_result),
        .alu_math_cout(alu_math_cout),
        .alu_rot_cout (alu_rot_cout),
        .alu_zero     (alu_zero),
        .alu_ovf      (alu_ovf),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .flags        (flags),
        .op_count     (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef ALU4_SEQ_OPCOUNT_EN
        return 32'(m_cnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 4'h0;
        m_f   = 4'h0;
        m_a   = 4'h0;
        m_b   = 4'h0;
        m_op  = 4'h0;
        m_rd  = 4'h0;
        m_cnt = 0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, ".flags"}, 32'(flags), 32'(m_f));
        chk({tag, ".cnt"}, 32'(op_count), exp_cnt());
        chk({tag, ".a"}, 32'(alu_a), 32'(m_a));
        chk({tag, ".b"}, 32'(alu_b), 32'(m_b));
        chk({tag, ".op"}, 32'(alu_op), 32'(m_op));
        chk({tag, ".rd"}, 32'(rd_data), 32'(m_rd));
    endtask

    task automatic do_load(input logic [1:0] r, input logic [3:0] v);
        cmd_valid = 1'b1;
        cmd = {2'b01, v, r, 2'b00};
        tick();
        cmd_valid = 1'b0;
        m_r[r] = v;
        chk("load.rdv", 32'(rd_valid), 32'd0);
        chk_idle("load");
    endtask

    task automatic do_read(input logic [1:0] r);
        cmd_valid = 1'b1;
        cmd = {2'b10, 4'h0, r, 2'b00};
        tick();
        cmd_valid = 1'b0;
        m_rd = m_r[r];
        chk("read.rdv", 32'(rd_valid), 32'd1);
        chk_idle("read");
        tick();
        chk("read.rdv_drop", 32'(rd_valid), 32'd0);
        chk("read.hold", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic do_clr();
        cmd_valid = 1'b1;
        cmd = {2'b11, 4'h0, 2'b00, 2'b00};
        tick();
        cmd_valid = 1'b0;
        m_f = 4'h0;
        m_cnt = 0;
        chk_idle("clr");
    endtask

    task automatic do_alu(input logic [1:0] d, input logic [1:0] s,
                          input logic [3:0] op, input logic [3:0] res,
                          input logic mc, input logic rc,
                          input logic z, input logic v);
        cmd_valid = 1'b1;
        cmd = {2'b00, op, d, s};
        tick();
        cmd_valid = 1'b0;
        m_a = m_r[d];
        m_b = m_r[s];
        m_op = op;
        chk("exec.ready", 32'(cmd_ready), 32'd0);
        chk("exec.a", 32'(alu_a), 32'(m_a));
        chk("exec.b", 32'(alu_b), 32'(m_b));
        chk("exec.op", 32'(alu_op), 32'(m_op));
        chk("exec.mcin", 32'(alu_math_cin), 32'(m_f[3]));
        chk("exec.rcin", 32'(alu_rot_cin), 32'(m_f[2]));
        alu_result = res;
        alu_math_cout = mc;
        alu_rot_cout = rc;
        alu_zero = z;
        alu_ovf = v;
        tick();
        m_r[d] = res;
        m_f = {mc, rc, z, v};
        if (m_cnt < 255) m_cnt++;
        chk_idle("wb");
    endtask

    initial begin
        logic [1:0] k, r, s;
        logic [3:0] v, res;
        logic [3:0] fl;

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd = '0;
        alu_result = '0;
        alu_math_cout = 1'b0;
        alu_rot_cout = 1'b0;
        alu_zero = 1'b0;
        alu_ovf = 1'b0;
        model_reset();

        #2;
        chk("rst.ready_low", 32'(cmd_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst.rdv", 32'(rd_valid), 32'd0);
        chk_idle("rst");

        // Load then read back-to-back
        tick();
        do_load(2'd2, 4'h7);
        do_read(2'd2);

        // Plan ALU op with stubbed result
        do_load(2'd0, 4'h9);
        do_load(2'd1, 4'h8);
        do_alu(2'd0, 2'd1, 4'h3, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("plan.flags", 32'(flags), 32'h9);
        do_read(2'd0);
        chk("plan.r0", 32'(rd_data), 32'h1);

        // Second op sees C=1 on alu_math_cin
        do_alu(2'd2, 2'd2, 4'h5, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0);
        do_read(2'd2);

        do_clr();
        chk("clr.flags", 32'(flags), 32'h0);

        // Random commands
        for (int n = 0; n < 80; n++) begin
            k = 2'($urandom_range(0, 3));
            r = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            v = 4'($urandom_range(0, 15));
            res = 4'($urandom_range(0, 15));
            fl = 4'($urandom_range(0, 15));
            unique case (k)
                2'b00: do_alu(r, s, v, res, fl[3], fl[2], fl[1], fl[0]);
                2'b01: do_load(r, v);
                2'b10: do_read(r);
                default: do_clr();
            endcase
        end
        for (int i = 0; i < 4; i++) do_read(2'(i));

        // Reset during EXEC discards the pending writeback
        do_load(2'd2, 4'hA);
        do_load(2'd3, 4'h6);
        cmd_valid = 1'b1;
        cmd = {2'b00, 4'h2, 2'd2, 2'd3};
        tick();
        chk("rexec.ready", 32'(cmd_ready), 32'd0);
        alu_result = 4'hF;
        alu_math_cout = 1'b1;
        alu_rot_cout = 1'b1;
        alu_zero = 1'b1;
        alu_ovf = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rexec.ready_low", 32'(cmd_ready), 32'd0);
        chk("rexec.flags", 32'(flags), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        cmd_valid = 1'b0;
        chk("rexec.rdv", 32'(rd_valid), 32'd0);
        chk_idle("rexec");
        tick();
        do_read(2'd2);
        chk("rexec.r2", 32'(rd_data), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
